// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack master, prefetch queue.
// Presents {pc, instr} to decode under valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DMAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WAIT_DROP
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_pc  [DEPTH];
  logic [31:0]   q_ins [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          xfer;
  logic          pop;
  logic          push;
  logic [CW-1:0] occ;
  logic          space_idle;
  logic          space_after;
  logic [31:0]   target;

  assign xfer   = imem_req && imem_ack;
  // a flush overrides both the pop and any returning word
  assign pop    = instr_valid && instr_ready && !redirect;
  assign push   = xfer && (state == WAIT) && !redirect;
  assign occ    = count - CW'(pop);
  assign target = redirect_pc & ~32'h3;

  assign space_idle  = occ < DMAX;
  assign space_after = occ < (DMAX - CW'(1));

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q_ins[rd_ptr] : 32'h0000_0013;
  assign instr_pc    = instr_valid ? q_pc[rd_ptr] : 32'h0;
  assign opcode      = instr[6:0];

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]  <= imem_addr;
      q_ins[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
      fetch_pc  <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end

      unique case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc  <= target;
            imem_req  <= 1'b1;
            imem_addr <= target;
            state     <= WAIT;
          end else if (space_idle) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (xfer && redirect) begin
            fetch_pc  <= target;
            imem_addr <= target;
          end else if (redirect) begin
            fetch_pc <= target;
            state    <= WAIT_DROP;
          end else if (xfer) begin
            fetch_pc <= imem_addr + 32'd4;
            if (space_after) begin
              imem_addr <= imem_addr + 32'd4;
            end else begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        WAIT_DROP: begin
          if (redirect) fetch_pc <= target;
          if (xfer) begin
            imem_addr <= redirect ? target : fetch_pc;
            state     <= WAIT;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable memory
// model and an expected-instruction queue.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        rdy = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = 32'h0;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk),
    .reset(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .opcode(opcode),
    .instr_ready(rdy),
    .redirect(redir),
    .redirect_pc(rpc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          lat = 0;
  int          wcnt = 0;
  int          n_xfer = 0;
  int          base;
  logic        force_ack = 1'b0;
  logic        drop = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hold_addr = 32'h0;
  logic [31:0] exp_next = 32'h0;
  logic [31:0] key = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic xf;
    logic pp;
    ent_t e;
    if (!rst) begin
      chk("valid", {31'b0, instr_valid}, {31'b0, sb.size() != 0});
      if (sb.size() != 0) begin
        chk("head_pc", instr_pc, sb[0].pc);
        chk("head_instr", instr, sb[0].ins);
        chk("head_opcode", {25'b0, opcode}, {25'b0, sb[0].ins[6:0]});
      end else begin
        chk("empty_instr", instr, 32'h13);
        chk("empty_pc", instr_pc, 32'h0);
        chk("empty_opcode", {25'b0, opcode}, 32'h13);
      end
      if (hold) begin
        chk("req_hold", {31'b0, imem_req}, 32'h1);
        chk("addr_hold", imem_addr, hold_addr);
      end
    end
    imem_ack   = force_ack || (imem_req && wcnt >= lat);
    imem_rdata = imem_addr ^ key;
    if (imem_req && !imem_ack) wcnt++;
    else wcnt = 0;
    xf = imem_req && imem_ack;
    pp = instr_valid && rdy;
    if (rst) begin
      sb.delete();
      exp_next = 32'h0;
      drop = 1'b0;
      hold = 1'b0;
    end else begin
      if (pp && !redir && sb.size() != 0) void'(sb.pop_front());
      if (xf) begin
        n_xfer++;
        if (!drop && !redir) begin
          chk("fetch_addr", imem_addr, exp_next);
          e.pc  = exp_next;
          e.ins = exp_next ^ key;
          sb.push_back(e);
          exp_next = exp_next + 32'd4;
        end
        drop = 1'b0;
      end
      if (redir) begin
        sb.delete();
        exp_next = rpc & ~32'h3;
        if (imem_req && !imem_ack) drop = 1'b1;
      end
      hold = imem_req && !imem_ack;
      hold_addr = imem_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_opcode", {25'b0, opcode}, 32'h13);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    chk_reset_vals();
    rst = 1'b0;
    step();
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals();

    // zero-wait memory, decode always ready: one per cycle
    lat = 0; rdy = 1'b1; key = 32'h0;
    do_reset();
    base = n_xfer;
    repeat (10) step();
    chk("stream_xfers", n_xfer - base, 10);
    chk("stream_req", {31'b0, imem_req}, 32'h1);

    // decode stalled: fill exactly DEPTH then stop
    rdy = 1'b0; key = 32'h5A00_0000;
    do_reset();
    base = n_xfer;
    repeat (5) step();
    chk("fill_xfers", n_xfer - base, 2);
    chk("fill_req", {31'b0, imem_req}, 32'h0);
    rdy = 1'b1;
    step();
    chk("refill_req", {31'b0, imem_req}, 32'h1);
    chk("refill_addr", imem_addr, 32'h8);
    repeat (6) step();

    // 3-cycle ack latency with random ready
    lat = 3; key = 32'h00C3_0000;
    do_reset();
    base = n_xfer;
    for (int i = 0; i < 40; i++) begin
      rdy = 1'($urandom_range(0, 1));
      step();
    end
    chk("slow_progress", {31'b0, (n_xfer - base) >= 5}, 32'h1);

    // redirect while request to 0x8 is outstanding
    rdy = 1'b1; key = 32'h1100_0000;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (imem_req && imem_addr == 32'h8) break;
      step();
    end
    chk("req8_seen", {31'b0, imem_req && imem_addr == 32'h8}, 32'h1);
    redir = 1'b1; rpc = 32'h0000_0103;
    step();
    redir = 1'b0;
    chk("drop_valid", {31'b0, instr_valid}, 32'h0);
    for (int i = 0; i < 30; i++) begin
      if (instr_valid) break;
      step();
    end
    chk("redir_first_pc", instr_pc, 32'h100);
    repeat (10) step();

    // redirect coinciding with ack and pop, queue non-empty
    lat = 0; key = 32'h0;
    do_reset();
    repeat (4) step();
    chk("pre_valid", {31'b0, instr_valid}, 32'h1);
    redir = 1'b1; rpc = 32'h0000_0200;
    step();
    redir = 1'b0;
    chk("flush_valid", {31'b0, instr_valid}, 32'h0);
    chk("flush_req", {31'b0, imem_req}, 32'h1);
    chk("flush_addr", imem_addr, 32'h200);
    repeat (5) step();

    // reset during WAIT, then a stray late ack
    lat = 3; key = 32'h0077_0000;
    do_reset();
    step();
    chk("wait_req", {31'b0, imem_req}, 32'h1);
    rst = 1'b1;
    step();
    chk_reset_vals();
    rst = 1'b0; force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk("late_valid", {31'b0, instr_valid}, 32'h0);
    chk("restart_req", {31'b0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr, 32'h0);
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V datapath, directly upstream of the decoder/`Controller`. Holds the program counter and issues word reads to instruction memory over a req/ack handshake. Buffers returned words in a 2-entry prefetch queue and presents them, with their PC, to decode under a valid/ready handshake. The `opcode` output is wired straight to the controller's `Opcode` input.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `DEPTH`, 2, prefetch queue entries; legal values are 2 and 4.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: fetch request, registered.
- `imem_addr` out 32: fetch address, registered, word-aligned.
- `imem_ack` in 1: memory response; the transfer completes in a cycle where `imem_req && imem_ack`.
- `imem_rdata` in 32: instruction word, valid only in the transfer cycle.
- `instr_valid` out 1: queue head holds a valid instruction.
- `instr` out 32: queue-head instruction; 32'h0000_0013 (NOP) when `instr_valid`=0.
- `instr_pc` out 32: PC of the queue head; 0 when `instr_valid`=0.
- `opcode` out 7: `instr[6:0]`, which is 7'b0010011 when the queue is empty.
- `instr_ready` in 1: decode accepts the head; pop occurs when `instr_valid && instr_ready`.
- `redirect` in 1: branch/jump taken; flush and refetch.
- `redirect_pc` in 32: new fetch target; bits [1:0] are forced to 0.

## Operation
- State: `fetch_pc` (next address to request), queue (`DEPTH` entries of {pc, instr}, plus count), FSM {IDLE, WAIT, WAIT_DROP}.
- Issue rule: in IDLE, when `count + pop_this_cycle_adjusted < DEPTH` (space for one more, counting the in-flight request), assert `imem_req` with `imem_addr` = `fetch_pc` next cycle, then go to WAIT.
- WAIT, on transfer: push {`imem_addr`, `imem_rdata`}; `fetch_pc` += 4.
  - If space remains after this push, net of a same-cycle pop, keep `imem_req`=1 with the new address and stay in WAIT (back-to-back).
  - Otherwise drop `imem_req` and go to IDLE.
- `imem_req`/`imem_addr` hold steady until ack; a request is never withdrawn.
- Redirect from IDLE: flush the queue (count=0), `fetch_pc` = `redirect_pc & ~3`; the next request uses the new target.
- Redirect while in WAIT without ack in the same cycle: flush the queue, latch the target into `fetch_pc`, go to WAIT_DROP. `imem_req` stays high with the old address until ack.
- WAIT_DROP, on ack: discard the data (no push), then issue `fetch_pc` next cycle. A further redirect while in WAIT_DROP just overwrites `fetch_pc`.
- Redirect in the same cycle as a transfer: the returned data is discarded, the queue is flushed, and the next request is to the redirect target.
- Redirect in the same cycle as a pop: the flush wins.
- Push and pop in the same cycle: both occur and the count is unchanged. Overflow is impossible by the issue rule; underflow cannot occur because a pop requires `instr_valid`.
- `imem_ack` while `imem_req`=0 is ignored.
- Queue pointers wrap modulo `DEPTH`.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=32'h13, `instr_pc`=0, `opcode`=7'b0010011, `fetch_pc`=`RESET_PC`, FSM=IDLE, count=0.
- First request: `imem_req`=1 with `imem_addr`=`RESET_PC` on the first cycle after `reset` falls.
- Latency: transfer in cycle N gives `instr_valid`=1 with that word in cycle N+1.
- Zero-wait memory (ack same cycle as req) with `instr_ready` held at 1: one instruction per cycle sustained.
- Redirect in cycle N from IDLE: `instr_valid`=0 in N+1; request to the target in N+1.
- Reset asserted mid-operation returns everything to reset values next edge; an outstanding memory response arriving later is ignored because `imem_req`=0.

## Test plan
- Reset then zero-wait memory returning `addr`, `instr_ready`=1 → requests 0,4,8,… on consecutive cycles; `instr_pc` 0,4,8 from cycle 2; `instr`=`instr_pc`.
- `instr_ready`=0 throughout → exactly `DEPTH` transfers (addresses 0,4), then `imem_req`=0. Raise `instr_ready` → pops 0 then 4, and request 8 is issued the cycle after the first pop.
- Memory with 3-cycle ack latency: `imem_addr` stays stable while `imem_req` is high; each word appears one cycle after its ack; no duplicates or skipped addresses.
- Redirect to 32'h0000_0103 while a request to 0x8 is outstanding → 0x8 data discarded; next request is 0x100; first valid `instr_pc`=0x100.
- Redirect in the same cycle as ack plus `instr_ready`=1 with a non-empty queue → queue empty next cycle, no push, target fetched next.
- Assert `reset` for 1 cycle during WAIT, then send a late ack → ack ignored; all outputs at reset values; fetch restarts at `RESET_PC`.
